// File: rtl/mux9_rr_arbiter_pkg.sv
// Shared definitions for the 9-requester round-robin arbiter.
//   N_REQ      : number of requesters sharing the datapath mux
//   SEL_W      : width of the mux select {s3,s2,s1,s0}
//   state_e    : arbiter FSM states
//   sel_encode : owner index (0..8) -> mux select code
package mux9_rr_arbiter_pkg;

  localparam int unsigned N_REQ = 9;
  localparam int unsigned SEL_W = 4;

  typedef enum logic {
    StIdle  = 1'b0,
    StGrant = 1'b1
  } state_e;

  // Owners 0..7 use the 8:1 stage directly; owner 8 is the lone input of the 2:1 stage.
  function automatic logic [SEL_W-1:0] sel_encode(input logic [3:0] owner);
    logic [SEL_W-1:0] code;
    if (owner == 4'd8) begin
      code = 4'b1000;
    end else begin
      code = {1'b0, owner[2:0]};
    end
    return code;
  endfunction

endpackage

// File: rtl/mux9_rr_arbiter_if.sv
// Requester/consumer bundle of the round-robin arbiter.
//   req, din, out_ready          : driven by the sources / downstream consumer
//   ack, gnt, sel, busy,
//   out_data, out_valid          : driven by the arbiter
// Modports: slave = arbiter side, master = sources/consumer side.
interface mux9_rr_arbiter_if #(
  parameter int unsigned WIDTH = 1
);

  logic [mux9_rr_arbiter_pkg::N_REQ-1:0]       req;
  logic [mux9_rr_arbiter_pkg::N_REQ*WIDTH-1:0] din;
  logic [mux9_rr_arbiter_pkg::N_REQ-1:0]       ack;
  logic [mux9_rr_arbiter_pkg::N_REQ-1:0]       gnt;
  logic [mux9_rr_arbiter_pkg::SEL_W-1:0]       sel;
  logic                                        busy;
  logic [WIDTH-1:0]                            out_data;
  logic                                        out_valid;
  logic                                        out_ready;

  modport master (
    output req, din, out_ready,
    input  ack, gnt, sel, busy, out_data, out_valid
  );

  modport slave (
    input  req, din, out_ready,
    output ack, gnt, sel, busy, out_data, out_valid
  );

endinterface

// File: rtl/mux9_datapath.sv
// Shared 9:1 datapath mux built as an 8:1 stage on sel[2:0] followed by a 2:1 stage on sel[3].
//   din  : 9 slots, slot k at din[k*WIDTH +: WIDTH]
//   sel  : {s3,s2,s1,s0}
//   dout : selected slot
module mux9_datapath #(
  parameter int unsigned WIDTH = 1
) (
  input  logic [9*WIDTH-1:0] din,
  input  logic [3:0]         sel,
  output logic [WIDTH-1:0]   dout
);

  logic [WIDTH-1:0] low;

  always_comb begin
    low  = din[int'(sel[2:0])*WIDTH +: WIDTH];
    dout = sel[3] ? din[8*WIDTH +: WIDTH] : low;
  end

endmodule

// File: rtl/mux9_rr_arbiter.sv
// Round-robin arbiter sharing one 9:1 datapath mux among 9 requesters, with a one-entry
// registered valid/ready output stage.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of mux9_rr_arbiter_if (req/din/out_ready in;
//                ack/gnt/sel/busy/out_data/out_valid out)
// An owner keeps the grant for up to MAX_HOLD accepted beats or until it drops req; every
// release passes through one idle arbitration cycle and moves the priority pointer past it.
module mux9_rr_arbiter
  import mux9_rr_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH    = 1,
  parameter int unsigned MAX_HOLD = 4
) (
  input logic              clk,
  input logic              rst_n,
  mux9_rr_arbiter_if.slave bus
);

  localparam int unsigned        CNT_W    = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(MAX_HOLD - 1);

  state_e             state_q, state_d;
  logic [3:0]         ptr_q, ptr_d;
  logic [3:0]         owner_q, owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               valid_q, valid_d;

  logic               busy;
  logic               load;
  logic [SEL_W-1:0]   sel;
  logic [N_REQ-1:0]   ack;
  logic [WIDTH-1:0]   mux_out;

  // First set request scanning ptr, ptr+1, ..., wrapping modulo 9.
  function automatic logic [3:0] rr_pick(input logic [N_REQ-1:0] r, input logic [3:0] p);
    logic [3:0] pick;
    int         idx;
    pick = p;
    // Walk from the farthest offset down so the nearest set bit wins.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = int'(p) + i;
      if (idx >= int'(N_REQ)) idx = idx - int'(N_REQ);
      if (r[idx]) pick = 4'(idx);
    end
    return pick;
  endfunction

  always_comb begin
    busy = (state_q == StGrant);
    sel  = busy ? sel_encode(owner_q) : '0;
    load = busy && bus.req[owner_q] && (!valid_q || bus.out_ready);
    ack  = '0;
    if (load) ack[owner_q] = 1'b1;
  end

  mux9_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .din (bus.din),
    .sel (sel),
    .dout(mux_out)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    case (state_q)
      StIdle: begin
        if (|bus.req) begin
          owner_d        = rr_pick(bus.req, ptr_q);
          gnt_d          = '0;
          gnt_d[owner_d] = 1'b1;
          cnt_d          = '0;
          state_d        = StGrant;
        end
      end
      StGrant: begin
        if (load) cnt_d = cnt_q + 1'b1;
        if ((load && (cnt_q == CNT_LAST)) || !bus.req[owner_q]) begin
          gnt_d   = '0;
          ptr_d   = (owner_q == 4'd8) ? 4'd0 : owner_q + 4'd1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output stage drains on out_ready regardless of FSM state.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load) begin
      data_d  = mux_out;
      valid_d = 1'b1;
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign bus.ack       = ack;
  assign bus.gnt       = gnt_q;
  assign bus.sel       = sel;
  assign bus.busy      = busy;
  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_mux9_rr_arbiter.sv
// Bench for mux9_rr_arbiter: two instances (MAX_HOLD=4 and MAX_HOLD=1) share one stimulus
// and are compared every cycle against a behavioural model, plus scenario-specific checks.
module tb_mux9_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [8:0] req = '0;
  logic [8:0] din = '0;
  logic       out_ready = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mux9_rr_arbiter_if #(.WIDTH(1)) ifa ();
  mux9_rr_arbiter_if #(.WIDTH(1)) ifb ();

  assign ifa.req = req;
  assign ifa.din = din;
  assign ifa.out_ready = out_ready;
  assign ifb.req = req;
  assign ifb.din = din;
  assign ifb.out_ready = out_ready;

  mux9_rr_arbiter #(.WIDTH(1), .MAX_HOLD(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  mux9_rr_arbiter #(.WIDTH(1), .MAX_HOLD(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  // Behavioural model: index 0 mirrors dut_a, index 1 mirrors dut_b.
  int hold[2] = '{4, 1};
  int m_on[2];
  int m_owner[2];
  int m_beats[2];
  int m_ptr[2];
  bit m_ov[2];
  bit m_od[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_on[k] = 0; m_owner[k] = 0; m_beats[k] = 0; m_ptr[k] = 0; m_ov[k] = 0; m_od[k] = 0;
    end
  endtask

  function automatic bit model_load(int k);
    return (m_on[k] != 0) && req[m_owner[k]] && (!m_ov[k] || out_ready);
  endfunction

  // {gnt, sel, busy, ack, out_valid, out_data}
  function automatic logic [24:0] model_out(int k);
    logic [8:0] g;
    logic [8:0] a;
    logic [3:0] s;
    g = '0; a = '0; s = '0;
    if (m_on[k] != 0) begin
      g[m_owner[k]] = 1'b1;
      s = (m_owner[k] == 8) ? 4'd8 : 4'(m_owner[k]);
      if (model_load(k)) a[m_owner[k]] = 1'b1;
    end
    return {g, s, (m_on[k] != 0), a, m_ov[k], m_od[k]};
  endfunction

  task automatic model_advance(int k);
    bit ld;
    bit found;
    ld = model_load(k);
    if (ld) begin
      m_od[k] = din[m_owner[k]];
      m_ov[k] = 1'b1;
    end else if (out_ready) begin
      m_ov[k] = 1'b0;
    end
    if (m_on[k] == 0) begin
      found = 0;
      for (int i = 0; i < 9; i++) begin
        if (!found && req[(m_ptr[k] + i) % 9]) begin
          m_owner[k] = (m_ptr[k] + i) % 9;
          found = 1;
        end
      end
      if (found) begin
        m_on[k] = 1;
        m_beats[k] = 0;
      end
    end else begin
      if (ld) m_beats[k]++;
      if ((ld && m_beats[k] == hold[k]) || !req[m_owner[k]]) begin
        m_on[k] = 0;
        m_ptr[k] = (m_owner[k] + 1) % 9;
      end
    end
  endtask

  function automatic logic [24:0] obs_a();
    return {ifa.gnt, ifa.sel, ifa.busy, ifa.ack, ifa.out_valid, ifa.out_data};
  endfunction

  function automatic logic [24:0] obs_b();
    return {ifb.gnt, ifb.sel, ifb.busy, ifb.ack, ifb.out_valid, ifb.out_data};
  endfunction

  task automatic advance();
    model_advance(0);
    model_advance(1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    din = '0;
    out_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 9'h1FF;
    out_ready = 1'b1;
    model_reset();
    for (int c = 0; c < 4; c++) begin
      din = 9'($urandom);
      @(negedge clk);
      n_tests++;
      if ({ifa.gnt, ifa.sel, ifa.busy, ifa.out_valid, ifb.gnt, ifb.sel, ifb.busy, ifb.out_valid}
          !== '0) begin
        n_fail++;
        $display("FAIL reset c=%0d: a gnt=%h sel=%h busy=%b ov=%b b gnt=%h sel=%h busy=%b ov=%b, want all 0",
                 c, ifa.gnt, ifa.sel, ifa.busy, ifa.out_valid, ifb.gnt, ifb.sel, ifb.busy,
                 ifb.out_valid);
      end
    end
    req = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_hold_limit();
    logic [8:0] exp_g;
    logic [3:0] exp_s;
    do_reset();
    req = 9'h008;
    for (int c = 0; c <= 6; c++) begin
      din = 9'($urandom);
      @(negedge clk);
      n_tests++;
      if (obs_a() !== model_out(0)) begin
        n_fail++;
        $display("FAIL hold_model_a c=%0d: got %h want %h", c, obs_a(), model_out(0));
      end
      exp_g = ((c >= 1 && c <= 4) || c == 6) ? 9'h008 : 9'h000;
      exp_s = (exp_g != 0) ? 4'b0011 : 4'b0000;
      n_tests++;
      if ({ifa.gnt, ifa.sel, ifa.ack} !== {exp_g, exp_s, exp_g}) begin
        n_fail++;
        $display("FAIL hold_limit c=%0d: gnt=%h sel=%b ack=%h want gnt=%h sel=%b ack=%h",
                 c, ifa.gnt, ifa.sel, ifa.ack, exp_g, exp_s, exp_g);
      end
      advance();
    end
  endtask

  task automatic test_fairness_wrap();
    logic [8:0] exp_g;
    logic [3:0] exp_s;
    int o;
    do_reset();
    req = 9'h1FF;
    for (int c = 0; c <= 20; c++) begin
      din = 9'($urandom);
      @(negedge clk);
      n_tests++;
      if (obs_b() !== model_out(1)) begin
        n_fail++;
        $display("FAIL fair_model_b c=%0d: got %h want %h", c, obs_b(), model_out(1));
      end
      exp_g = '0;
      exp_s = '0;
      if (c % 2 == 1) begin
        o = ((c - 1) / 2) % 9;
        exp_g[o] = 1'b1;
        exp_s = (o == 8) ? 4'b1000 : 4'(o);
      end
      n_tests++;
      if ({ifb.gnt, ifb.sel} !== {exp_g, exp_s}) begin
        n_fail++;
        $display("FAIL fairness c=%0d: gnt=%h sel=%b want gnt=%h sel=%b",
                 c, ifb.gnt, ifb.sel, exp_g, exp_s);
      end
      advance();
    end
  endtask

  task automatic test_backpressure();
    logic d_held;
    d_held = 1'b0;
    do_reset();
    req = 9'h020;
    for (int c = 0; c <= 9; c++) begin
      din = 9'($urandom);
      out_ready = (c >= 2 && c <= 4) ? 1'b0 : 1'b1;
      if (c == 1) d_held = din[5];
      @(negedge clk);
      n_tests++;
      if (obs_a() !== model_out(0) || obs_b() !== model_out(1)) begin
        n_fail++;
        $display("FAIL bp_model c=%0d: a=%h want %h b=%h want %h",
                 c, obs_a(), model_out(0), obs_b(), model_out(1));
      end
      if (c >= 2 && c <= 4) begin
        n_tests++;
        if ({ifa.ack, ifa.out_valid, ifa.out_data, ifa.gnt} !== {9'h000, 1'b1, d_held, 9'h020}) begin
          n_fail++;
          $display("FAIL backpressure_stall c=%0d: ack=%h ov=%b od=%b gnt=%h want 000 1 %b 020",
                   c, ifa.ack, ifa.out_valid, ifa.out_data, ifa.gnt, d_held);
        end
      end else if (c >= 5 && c <= 7) begin
        n_tests++;
        if (ifa.ack !== 9'h020) begin
          n_fail++;
          $display("FAIL backpressure_resume c=%0d: ack=%h want 020", c, ifa.ack);
        end
      end else if (c == 8) begin
        n_tests++;
        if (ifa.gnt !== 9'h000) begin
          n_fail++;
          $display("FAIL backpressure_release c=%0d: gnt=%h want 000", c, ifa.gnt);
        end
      end
      advance();
    end
  endtask

  task automatic test_early_drop();
    logic d_last;
    d_last = 1'b0;
    do_reset();
    for (int c = 0; c <= 6; c++) begin
      din = 9'($urandom);
      req = (c < 3) ? 9'h044 : 9'h040;
      if (c == 2) d_last = din[2];
      @(negedge clk);
      n_tests++;
      if (obs_a() !== model_out(0) || obs_b() !== model_out(1)) begin
        n_fail++;
        $display("FAIL drop_model c=%0d: a=%h want %h b=%h want %h",
                 c, obs_a(), model_out(0), obs_b(), model_out(1));
      end
      if (c == 3) begin
        n_tests++;
        if ({ifa.out_valid, ifa.out_data, ifa.ack} !== {1'b1, d_last, 9'h000}) begin
          n_fail++;
          $display("FAIL drop_last_beat: ov=%b od=%b ack=%h want 1 %b 000",
                   ifa.out_valid, ifa.out_data, ifa.ack, d_last);
        end
      end else if (c == 4 || c == 5) begin
        n_tests++;
        if (ifa.gnt !== ((c == 5) ? 9'h040 : 9'h000)) begin
          n_fail++;
          $display("FAIL drop_regrant c=%0d: gnt=%h want %h",
                   c, ifa.gnt, (c == 5) ? 9'h040 : 9'h000);
        end
      end
      advance();
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 9'h080;
    out_ready = 1'b0;
    for (int c = 0; c <= 2; c++) begin
      din = 9'($urandom);
      @(negedge clk);
      n_tests++;
      if (obs_a() !== model_out(0)) begin
        n_fail++;
        $display("FAIL arst_model_a c=%0d: got %h want %h", c, obs_a(), model_out(0));
      end
      if (c < 2) advance();
    end
    n_tests++;
    if ({ifa.gnt, ifa.out_valid} !== {9'h080, 1'b1}) begin
      n_fail++;
      $display("FAIL arst_precond: gnt=%h ov=%b want 080 1", ifa.gnt, ifa.out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({obs_a(), obs_b()} !== '0) begin
      n_fail++;
      $display("FAIL arst_clear: a=%h b=%h want 0", obs_a(), obs_b());
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c <= 3; c++) begin
      din = 9'($urandom);
      @(negedge clk);
      n_tests++;
      if (obs_a() !== model_out(0) || obs_b() !== model_out(1)) begin
        n_fail++;
        $display("FAIL arst_after c=%0d: a=%h want %h b=%h want %h",
                 c, obs_a(), model_out(0), obs_b(), model_out(1));
      end
      if (c == 1) begin
        n_tests++;
        if (ifa.gnt !== 9'h080) begin
          n_fail++;
          $display("FAIL arst_regrant: gnt=%h want 080", ifa.gnt);
        end
      end
      advance();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(3) == 0) req = 9'($urandom);
      din = 9'($urandom);
      out_ready = ($urandom_range(3) != 0);
      @(negedge clk);
      n_tests++;
      if (obs_a() !== model_out(0) || obs_b() !== model_out(1)) begin
        n_fail++;
        $display("FAIL random c=%0d req=%h rdy=%b: a=%h want %h b=%h want %h",
                 c, req, out_ready, obs_a(), model_out(0), obs_b(), model_out(1));
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_hold_limit();
    test_fairness_wrap();
    test_backpressure();
    test_early_drop();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
